// File: rtl/imem_loader_if.sv
// Bundle between the boot loader/instruction memory and its neighbours:
// the byte-stream programming port, load control/status and the core fetch path.
interface imem_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              load_start;
   logic [ADDR_W:0]   load_len;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              len_err;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] instr;
   logic              halted;

   modport slave (
      input  load_start, load_len, byte_valid, byte_data, pc,
      output byte_ready, cpu_reset, busy, done, len_err, instr, halted
   );

   modport master (
      output load_start, load_len, byte_valid, byte_data, pc,
      input  byte_ready, cpu_reset, busy, done, len_err, instr, halted
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction RAM with a byte-stream boot loader; holds the core in reset while
// programming and serves instructions combinationally once released.
module imem_loader #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800,
   parameter logic [4:0]        HALT_OP  = 5'b11011
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus
);
   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, RECV_HI, RECV_LO, RELEASE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [7:0]        hi_q, hi_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              len_err_q, len_err_d;
   logic              halted_q, halted_d;

   logic              byte_ready;
   logic              mem_we;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] mem [DEPTH];

   // Asynchronous read: the single-cycle core needs the word in the same cycle as pc.
   assign rd_word = mem[bus.pc];

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_addr_q] <= {hi_q, bus.byte_data};
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      word_cnt_d  = word_cnt_q;
      len_d       = len_q;
      hi_d        = hi_q;
      cpu_reset_d = cpu_reset_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      len_err_d   = 1'b0;
      halted_d    = halted_q;
      byte_ready  = 1'b0;
      mem_we      = 1'b0;

      if (!cpu_reset_q && (rd_word[DATA_W-1 -: 5] == HALT_OP)) begin
         halted_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.load_start) begin
               if (bus.load_len == '0) begin
                  done_d      = 1'b1;
                  cpu_reset_d = 1'b0;
                  halted_d    = 1'b0;
               end else if (bus.load_len > MAX_LEN) begin
                  len_err_d = 1'b1;
               end else begin
                  len_d       = bus.load_len;
                  wr_addr_d   = '0;
                  word_cnt_d  = '0;
                  cpu_reset_d = 1'b1;
                  busy_d      = 1'b1;
                  halted_d    = 1'b0;
                  state_d     = RECV_HI;
               end
            end
         end
         RECV_HI: begin
            byte_ready = 1'b1;
            if (bus.byte_valid) begin
               hi_d    = bus.byte_data;
               state_d = RECV_LO;
            end
         end
         RECV_LO: begin
            byte_ready = 1'b1;
            if (bus.byte_valid) begin
               mem_we = 1'b1;
               // Stop on the last word so a 256-word load never wraps back to address 0.
               if (word_cnt_q + 1'b1 == len_q) begin
                  state_d = RELEASE;
               end else begin
                  wr_addr_d  = wr_addr_q + 1'b1;
                  word_cnt_d = word_cnt_q + 1'b1;
                  state_d    = RECV_HI;
               end
            end
         end
         RELEASE: begin
            cpu_reset_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wr_addr_q   <= '0;
         word_cnt_q  <= '0;
         len_q       <= '0;
         hi_q        <= '0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         len_err_q   <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         word_cnt_q  <= word_cnt_d;
         len_q       <= len_d;
         hi_q        <= hi_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         len_err_q   <= len_err_d;
         halted_q    <= halted_d;
      end
   end

   assign bus.byte_ready = byte_ready;
   assign bus.cpu_reset  = cpu_reset_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.len_err    = len_err_q;
   assign bus.halted     = halted_q;
   assign bus.instr      = cpu_reset_q ? NOP_WORD : rd_word;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected words are queued as programs are
// streamed in and popped when the words are fetched back through pc/instr.
module tb_imem_loader;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   imem_loader_if bus ();
   imem_loader dut (.clk(clk), .reset(reset), .bus(bus));

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] prog [256];
   logic [15:0] exp_q [$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic run_load(input int len, input bit toggle, input int stop_after, output int rdy);
      int nbytes, idx, cyc;
      logic [15:0] w;
      rdy = 0; idx = 0; cyc = 0;
      nbytes = (stop_after >= 0) ? stop_after : 2 * len;
      if (stop_after < 0) for (int i = 0; i < len; i++) exp_q.push_back(prog[i]);
      bus.pc = '0;
      bus.load_start = 1'b1;
      bus.load_len = 9'(len);
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b want 1", bus.busy); end
      n_vec++; if (bus.cpu_reset !== 1'b1) begin n_err++; $display("FAIL start_cpu_reset: got %b want 1", bus.cpu_reset); end
      n_vec++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL start_halted_clear: got %b want 0", bus.halted); end
      while (idx < nbytes && cyc < 4 * nbytes + 20) begin
         w = prog[idx / 2];
         bus.byte_valid = toggle ? (cyc % 2 == 1) : 1'b1;
         bus.byte_data = (idx % 2 == 1) ? w[7:0] : w[15:8];
         @(negedge clk);
         if (bus.byte_ready) rdy++;
         if (bus.byte_ready && bus.byte_valid) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      bus.byte_valid = 1'b0;
      n_vec++; if (idx != nbytes) begin n_err++; $display("FAIL byte_timeout: got %0d bytes want %0d", idx, nbytes); end
      if (stop_after < 0) begin
         bus.byte_valid = 1'b1;
         bus.byte_data = 8'hEE;
         @(negedge clk);
         n_vec++; if (bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL release_ready: got %b want 0", bus.byte_ready); end
         n_vec++; if (bus.cpu_reset !== 1'b1) begin n_err++; $display("FAIL release_cpu_reset: got %b want 1", bus.cpu_reset); end
         n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL release_done: got %b want 0", bus.done); end
         n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL release_busy: got %b want 1", bus.busy); end
         @(posedge clk); #1;
         @(negedge clk);
         n_vec++; if (bus.cpu_reset !== 1'b0) begin n_err++; $display("FAIL done_cpu_reset: got %b want 0", bus.cpu_reset); end
         n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL done_pulse: got %b want 1", bus.done); end
         n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL done_busy: got %b want 0", bus.busy); end
         n_vec++; if (bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL done_ready: got %b want 0", bus.byte_ready); end
         @(posedge clk); #1;
         @(negedge clk);
         n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_single: got %b want 0", bus.done); end
         @(posedge clk); #1;
         bus.byte_valid = 1'b0;
         $display("load len=%0d toggle=%0d complete, %0d ready cycles", len, toggle, rdy);
      end else begin
         $display("load len=%0d stopped after %0d bytes", len, idx);
      end
   endtask

   task automatic check_ram(input int n);
      logic [15:0] e;
      for (int i = 0; i < n; i++) begin
         bus.pc = 8'(i);
         @(negedge clk);
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++; $display("FAIL ram_sb_empty: got empty queue want entry for pc=%0d", i);
         end else begin
            e = exp_q.pop_front();
            if (bus.instr !== e) begin n_err++; $display("FAIL ram_word pc=%0d: got %h want %h", i, bus.instr, e); end
         end
         @(posedge clk); #1;
      end
      bus.pc = '0;
      $display("fetched %0d words back", n);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.load_start = 1'b0; bus.load_len = '0; bus.byte_valid = 1'b0;
      bus.byte_data = '0; bus.pc = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      n_vec++; if (bus.cpu_reset !== 1'b1) begin n_err++; $display("FAIL rst_cpu_reset: got %b want 1", bus.cpu_reset); end
      n_vec++; if (bus.instr !== 16'h0800) begin n_err++; $display("FAIL rst_instr: got %h want 0800", bus.instr); end
      n_vec++; if (bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.byte_ready); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_vec++; if ({bus.done, bus.len_err, bus.halted} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {bus.done, bus.len_err, bus.halted}); end
      @(posedge clk); #1;
      $display("reset checked");
   endtask

   task automatic test_basic_load();
      int rdy;
      prog[0] = 16'h99C3; prog[1] = 16'h0800; prog[2] = 16'hD800;
      run_load(3, 1'b0, -1, rdy);
      n_vec++; if (rdy != 6) begin n_err++; $display("FAIL basic_ready_cycles: got %0d want 6", rdy); end
      check_ram(3);
   endtask

   task automatic test_toggle_load();
      int rdy;
      run_load(3, 1'b1, -1, rdy);
      n_vec++; if (rdy != 12) begin n_err++; $display("FAIL toggle_ready_cycles: got %0d want 12", rdy); end
      check_ram(3);
   endtask

   task automatic test_halt();
      int rdy;
      logic [15:0] e;
      run_load(3, 1'b0, -1, rdy);
      n_vec++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL halt_initial: got %b want 0", bus.halted); end
      for (int i = 0; i < 3; i++) begin
         bus.pc = 8'(i);
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++; if (bus.instr !== e) begin n_err++; $display("FAIL halt_fetch pc=%0d: got %h want %h", i, bus.instr, e); end
         n_vec++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL halt_early pc=%0d: got %b want 0", i, bus.halted); end
         @(posedge clk); #1;
      end
      bus.pc = '0;
      @(negedge clk);
      n_vec++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL halt_set: got %b want 1", bus.halted); end
      n_vec++; if (bus.instr !== 16'h99C3) begin n_err++; $display("FAIL halt_pc0_instr: got %h want 99C3", bus.instr); end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b want 1", bus.halted); end
      @(posedge clk); #1;
      $display("halt detection checked");
      run_load(3, 1'b0, -1, rdy);
      check_ram(3);
   endtask

   task automatic test_full_depth();
      int rdy;
      logic [7:0] b;
      for (int i = 0; i < 256; i++) begin
         b = 8'(i);
         prog[i] = {b, ~b};
      end
      run_load(256, 1'b0, -1, rdy);
      n_vec++; if (rdy != 512) begin n_err++; $display("FAIL full_ready_cycles: got %0d want 512", rdy); end
      check_ram(256);
   endtask

   task automatic test_reset_mid_load();
      int rdy;
      prog[0] = 16'h1234; prog[1] = 16'h5678; prog[2] = 16'h9ABC; prog[3] = 16'hDEF0;
      run_load(4, 1'b0, 3, rdy);
      n_vec++; if (bus.byte_ready !== 1'b1) begin n_err++; $display("FAIL midload_ready: got %b want 1", bus.byte_ready); end
      #1 reset = 1'b0;
      #1;
      n_vec++; if (bus.cpu_reset !== 1'b1) begin n_err++; $display("FAIL async_cpu_reset: got %b want 1", bus.cpu_reset); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", bus.busy); end
      n_vec++; if (bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL async_ready: got %b want 0", bus.byte_ready); end
      n_vec++; if (bus.instr !== 16'h0800) begin n_err++; $display("FAIL async_instr: got %h want 0800", bus.instr); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL async_no_done: got %b want 0", bus.done); end
      @(posedge clk); #1;
      $display("async reset mid-load checked");
   endtask

   task automatic test_len_err();
      int rdy;
      bus.load_start = 1'b1; bus.load_len = 9'd300;
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.len_err !== 1'b1) begin n_err++; $display("FAIL lenerr_pulse: got %b want 1", bus.len_err); end
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL lenerr_done: got %b want 0", bus.done); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL lenerr_busy: got %b want 0", bus.busy); end
      n_vec++; if (bus.cpu_reset !== 1'b1) begin n_err++; $display("FAIL lenerr_cpu_reset: got %b want 1", bus.cpu_reset); end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++; if (bus.len_err !== 1'b0) begin n_err++; $display("FAIL lenerr_single: got %b want 0", bus.len_err); end
      n_vec++; if (bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL lenerr_ready: got %b want 0", bus.byte_ready); end
      @(posedge clk); #1;
      bus.load_start = 1'b1; bus.load_len = 9'd0;
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL len0_done: got %b want 1", bus.done); end
      n_vec++; if (bus.cpu_reset !== 1'b0) begin n_err++; $display("FAIL len0_cpu_reset: got %b want 0", bus.cpu_reset); end
      n_vec++; if (bus.len_err !== 1'b0) begin n_err++; $display("FAIL len0_len_err: got %b want 0", bus.len_err); end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL len0_single: got %b want 0", bus.done); end
      @(posedge clk); #1;
      $display("len_err and zero-length start checked");
      // RAM[0] came from the interrupted load; RAM[1] still holds the 256-word image.
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'h01FE);
      check_ram(2);
      run_load(4, 1'b0, -1, rdy);
      check_ram(4);
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_toggle_load();
      test_halt();
      test_full_depth();
      test_reset_mid_load();
      test_len_err();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction memory and boot loader sitting directly upstream of the single-cycle 16-bit mips core; it drives the core's instr input from the core's pc.
- A byte-stream programming port (valid/ready) assembles big-endian 16-bit instruction words into a 256-entry RAM while holding the core in reset.
- On completion it releases the core.
- It serves instructions combinationally and flags a sticky halt when a HALT opcode is fetched.

Parameters:
ADDR_W, 8, instruction address width (matches core pc); depth = 2**ADDR_W
DATA_W, 16, instruction word width
NOP_WORD, 16'h0800, word driven on instr while the core is held ({NOP=5'b00001, 11'h0})
HALT_OP, 5'b11011, opcode field value (instr[15:11]) detected as HALT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
load_start  in  1  one-cycle request to begin a load; sampled only in IDLE
load_len  in  9  number of words to load, 0..256; sampled with load_start
byte_valid  in  1  byte_data valid
byte_data  in  8  programming byte; high byte of each word first
byte_ready  out  1  loader accepts byte this cycle (transfer = byte_valid & byte_ready)
cpu_reset  out  1  active-high reset to mips core
busy  out  1  load in progress
done  out  1  one-cycle pulse when a load completes
len_err  out  1  one-cycle pulse when load_start is rejected for load_len > 256
pc  in  ADDR_W  fetch address from core
instr  out  DATA_W  instruction to core
halted  out  1  sticky: HALT fetched while core running

Behaviour:
- Reset (reset=0, async): state=IDLE; cpu_reset=1, busy=0, done=0, len_err=0, byte_ready=0, halted=0; internal wr_addr=0, word counter=0, hi-byte register=0. RAM contents are not cleared.
- FSM states: IDLE, RECV_HI, RECV_LO, RELEASE.
- IDLE:
  - byte_ready=0.
  - load_start & 1<=load_len<=256: latch len, wr_addr<=0; next RECV_HI; cpu_reset<=1, busy<=1, halted<=0.
  - load_len==0: done pulses next cycle; cpu_reset<=0; RAM untouched.
  - load_len>256: len_err pulses next cycle; state, cpu_reset and halted unchanged.
- RECV_HI: byte_ready=1. On transfer, latch byte into hi register; next RECV_LO.
- RECV_LO:
  - byte_ready=1.
  - On transfer: RAM[wr_addr] <= {hi, byte_data}, write happens at this clock edge.
  - If this was word len-1, next RELEASE; else wr_addr+1, next RECV_HI.
- RELEASE: one cycle with cpu_reset=1, busy=1. Next IDLE with cpu_reset<=0, busy<=0, done pulses 1 in that first IDLE cycle. The core thus sees at least one full reset cycle after the last write.
- byte_valid=0 stalls indefinitely in RECV_HI/RECV_LO without state change. Bytes offered in IDLE/RELEASE are not accepted.
- load_start while busy: ignored, no error.
- wr_addr counts 0..len-1. With len=256 the last write is address 255; no wrap-around write occurs.
- Fetch:
  - instr = cpu_reset ? NOP_WORD : RAM[pc], combinational (asynchronous read), zero latency. Matches a single-cycle core.
  - Read and write never collide, since reads are masked during load.
- halted:
  - Set on a rising clock edge when cpu_reset=0 and RAM[pc][15:11]==HALT_OP.
  - Stays set until reset or an accepted load_start; does not stop the core itself.
- Reset asserted mid-load:
  - Immediate return to IDLE, cpu_reset=1, no done.
  - Words already written remain. The core stays held until a new successful load (or len 0 start).
- done and len_err are single-cycle pulses, never both in one cycle.

Test Plan:
- After reset release, check cpu_reset=1, instr=16'h0800, byte_ready=0. Then load_start, load_len=3, bytes 99,C3,08,00,D8,00 with byte_valid continuous.
  - byte_ready=1 for 6 cycles.
  - RAM[0..2]=99C3,0800,D800.
  - cpu_reset falls exactly 2 cycles after the last byte transfer, coinciding with done=1.
  - instr=99C3 at pc=0.
- Same load with byte_valid toggled 1/0 every cycle: identical RAM contents; completes after 12 data cycles with no lost or duplicated bytes.
- With the program above running, drive pc=0,1,2: instr=99C3, 0800, D800; halted rises on the edge at pc=2 and stays 1 at pc=0. A new load_start clears it.
- load_len=300: len_err pulses once, busy stays 0, cpu_reset unchanged. load_len=0: done pulses, cpu_reset drops, RAM unchanged.
- load_len=256 with word i = {i[7:0], ~i[7:0]}: RAM[255]=16'hFF00, RAM[0]=16'h00FF, done once, no extra byte accepted.
- Assert reset after 3 bytes of a 4-word load:
  - Outputs return to reset values asynchronously.
  - RAM[0] holds the first word; RAM[1] is not written.
  - A subsequent full load completes normally.
